// File: rtl/spectro_band_accumulator.sv
// spectro_band_accumulator
//   Integrates one unsigned magnitude per band over a frame of FRAME_LEN accepted beats,
//   saturating each band independently. At frame end the sums are latched into a shadow
//   buffer and drained one band per beat over a valid/ready stream. A frame that ends
//   while the shadow buffer is still occupied is dropped and flags a sticky overrun.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   sample beat strobe (always accepted)
//   in_data    band b at [b*IN_W +: IN_W]
//   out_valid  shadow word presented
//   out_ready  consumer accepts the word
//   out_data   scaled, clamped sum of the current band
//   out_band   index of the current band
//   out_last   high with the final band
//   frame_id   latched frame count, mod 256
//   overrun    sticky dropped-frame flag
module spectro_band_accumulator #(
    parameter int unsigned NUM_BANDS = 8,
    parameter int unsigned IN_W      = 8,
    parameter int unsigned ACC_W     = 16,
    parameter int unsigned FRAME_LEN = 256,
    parameter int unsigned OUT_SHIFT = 8,
    parameter int unsigned OUT_W     = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [NUM_BANDS*IN_W-1:0]    in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [OUT_W-1:0]             out_data,
    output logic [$clog2(NUM_BANDS)-1:0] out_band,
    output logic                         out_last,
    output logic [7:0]                   frame_id,
    output logic                         overrun
);

    localparam int unsigned IdxW  = $clog2(NUM_BANDS);
    localparam int unsigned CntW  = $clog2(FRAME_LEN);
    localparam int unsigned WideW = (ACC_W > OUT_W) ? ACC_W : OUT_W;

    typedef enum logic [0:0] {StIdle, StDrain} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [7:0]        frame_id_q, frame_id_d;
    logic              overrun_q, overrun_d;
    logic [ACC_W-1:0]  acc_q    [NUM_BANDS];
    logic [ACC_W-1:0]  acc_d    [NUM_BANDS];
    logic [ACC_W-1:0]  shadow_q [NUM_BANDS];
    logic [ACC_W-1:0]  cand     [NUM_BANDS];

    logic              frame_end;
    logic              idx_last;
    logic              shadow_load;
    logic [ACC_W:0]    sum_wide;
    logic [WideW-1:0]  shifted_wide;

    assign frame_end = in_valid && (cnt_q == CntW'(FRAME_LEN - 1));
    assign idx_last  = (idx_q == IdxW'(NUM_BANDS - 1));

    // Saturating per-band sums; cand is also the candidate frame on the frame-end beat.
    always_comb begin
        sum_wide = '0;
        for (int b = 0; b < NUM_BANDS; b++) begin
            sum_wide = {1'b0, acc_q[b]} + (ACC_W + 1)'(in_data[b*IN_W +: IN_W]);
            cand[b]  = sum_wide[ACC_W] ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
            acc_d[b] = acc_q[b];
            if (in_valid) begin
                acc_d[b] = frame_end ? '0 : cand[b];
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (in_valid) begin
            cnt_d = frame_end ? '0 : cnt_q + 1'b1;
        end
    end

    // Buffer FSM. The final handshake frees the shadow in the same cycle, so a frame end
    // coinciding with it is latched rather than dropped.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        frame_id_d  = frame_id_q;
        overrun_d   = overrun_q;
        shadow_load = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (frame_end) begin
                    shadow_load = 1'b1;
                    idx_d       = '0;
                    frame_id_d  = frame_id_q + 8'd1;
                    state_d     = StDrain;
                end
            end
            StDrain: begin
                if (out_ready && !idx_last) begin
                    idx_d = idx_q + 1'b1;
                end
                if (out_ready && idx_last) begin
                    idx_d   = '0;
                    state_d = StIdle;
                    if (frame_end) begin
                        shadow_load = 1'b1;
                        frame_id_d  = frame_id_q + 8'd1;
                        state_d     = StDrain;
                    end
                end else if (frame_end) begin
                    overrun_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            idx_q      <= '0;
            frame_id_q <= '0;
            overrun_q  <= 1'b0;
            for (int b = 0; b < NUM_BANDS; b++) begin
                acc_q[b]    <= '0;
                shadow_q[b] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            frame_id_q <= frame_id_d;
            overrun_q  <= overrun_d;
            for (int b = 0; b < NUM_BANDS; b++) begin
                acc_q[b] <= acc_d[b];
                if (shadow_load) begin
                    shadow_q[b] <= cand[b];
                end
            end
        end
    end

    // Shift then clamp to the output range, evaluated in a width that holds both.
    always_comb begin
        shifted_wide = WideW'(shadow_q[idx_q] >> OUT_SHIFT);
        if (shifted_wide > WideW'({OUT_W{1'b1}})) begin
            out_data = {OUT_W{1'b1}};
        end else begin
            out_data = shifted_wide[OUT_W-1:0];
        end
    end

    assign out_valid = (state_q == StDrain);
    assign out_band  = idx_q;
    assign out_last  = (state_q == StDrain) && idx_last;
    assign frame_id  = frame_id_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_spectro_band_accumulator.sv
module tb_spectro_band_accumulator;

    localparam int NB = 4;
    localparam int IW = 8;
    localparam int AW = 9;
    localparam int FL = 4;
    localparam int SH = 2;
    localparam int OW = 6;

    localparam int ACC_MAX = (1 << AW) - 1;
    localparam int OUT_MAX = (1 << OW) - 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic [NB*IW-1:0] in_data = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [OW-1:0]   out_data;
    logic [1:0]      out_band;
    logic            out_last;
    logic [7:0]      frame_id;
    logic            overrun;

    spectro_band_accumulator #(
        .NUM_BANDS(NB), .IN_W(IW), .ACC_W(AW), .FRAME_LEN(FL), .OUT_SHIFT(SH), .OUT_W(OW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_band (out_band),
        .out_last (out_last),
        .frame_id (frame_id),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: running sums, words still waiting in the shadow, and counters.
    int m_acc [NB];
    int m_shadow [NB];
    int m_beats   = 0;
    int m_pending = 0;
    int m_fid     = 0;
    int m_ovr     = 0;
    bit m_after_rst = 1'b1;

    task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    function automatic int sat_min(input int a, input int lim);
        return (a > lim) ? lim : a;
    endfunction

    task automatic model_step(input bit r, input bit v, input logic [31:0] d, input bit rdy);
        int  cand [NB];
        bit  fend;
        if (r) begin
            for (int b = 0; b < NB; b++) begin
                m_acc[b]    = 0;
                m_shadow[b] = 0;
            end
            m_beats = 0; m_pending = 0; m_fid = 0; m_ovr = 0;
            m_after_rst = 1'b1;
            return;
        end
        m_after_rst = 1'b0;
        fend = v && (m_beats == FL - 1);
        for (int b = 0; b < NB; b++) begin
            cand[b] = sat_min(m_acc[b] + int'(d[b*8 +: 8]), ACC_MAX);
            if (v) m_acc[b] = fend ? 0 : cand[b];
        end
        if (v) m_beats = fend ? 0 : m_beats + 1;
        if (m_pending > 0 && rdy) m_pending--;
        if (fend) begin
            if (m_pending == 0) begin
                for (int b = 0; b < NB; b++) m_shadow[b] = cand[b];
                m_pending = NB;
                m_fid     = (m_fid + 1) % 256;
            end else begin
                m_ovr = 1;
            end
        end
    endtask

    // One clock: compare outputs against the model, drive the next inputs, advance the model.
    task automatic cyc(input bit r, input bit v, input logic [31:0] d, input bit rdy);
        int band;
        @(negedge clk);
        band = (m_pending > 0) ? NB - m_pending : 0;
        check_eq("out_valid", out_valid, (m_pending > 0) ? 1 : 0);
        check_eq("out_last", out_last, (m_pending == 1) ? 1 : 0);
        if (m_pending > 0 || m_after_rst) begin
            check_eq("out_band", out_band, band);
            check_eq("out_data", out_data, sat_min(m_shadow[band] >> SH, OUT_MAX));
        end
        check_eq("frame_id", frame_id, m_fid);
        check_eq("overrun", overrun, m_ovr);
        rst       = r;
        in_valid  = v;
        in_data   = d;
        out_ready = rdy;
        model_step(r, v, d, rdy);
    endtask

    function automatic logic [31:0] rep(input int val);
        logic [7:0] x;
        x = val[7:0];
        return {x, x, x, x};
    endfunction

    function automatic logic [31:0] rnd_word();
        logic [31:0] w;
        for (int b = 0; b < NB; b++) begin
            w[b*8 +: 8] = ($urandom % 2 == 0) ? 8'($urandom_range(0, 40))
                                              : 8'($urandom_range(0, 255));
        end
        return w;
    endfunction

    initial begin
        int gap_pat [10] = '{1, 0, 1, 0, 0, 1, 0, 1, 0, 0};
        for (int b = 0; b < NB; b++) begin
            m_acc[b] = 0;
            m_shadow[b] = 0;
        end

        // Reset
        repeat (2) cyc(1, 0, 0, 0);

        // Basic frame of 10s
        repeat (4) cyc(0, 1, rep(10), 1);
        repeat (6) cyc(0, 0, 0, 1);

        // Saturation and clamp
        repeat (4) cyc(0, 1, 32'h6400_01FF, 1);
        repeat (6) cyc(0, 0, 0, 1);

        // Simultaneous frame end and final handshake
        repeat (8) cyc(0, 1, rep(5 + ($urandom % 3)), 1);
        repeat (6) cyc(0, 0, 0, 1);

        // in_valid gaps
        for (int i = 0; i < 10; i++) cyc(0, gap_pat[i][0], rep(2), 1);
        repeat (6) cyc(0, 0, 0, 1);

        // Backpressure and overrun
        repeat (4) cyc(0, 1, rep(12), 0);
        repeat (4) cyc(0, 1, rep(30), 0);
        repeat (3) cyc(0, 0, 0, 0);
        repeat (6) cyc(0, 0, 0, 1);

        // Reset mid-drain, then a fresh frame
        repeat (4) cyc(0, 1, rep(7), 1);
        repeat (2) cyc(0, 0, 0, 1);
        cyc(1, 0, 0, 1);
        cyc(0, 0, 0, 1);
        repeat (4) cyc(0, 1, rep(20), 1);
        repeat (6) cyc(0, 0, 0, 1);

        // Long random run, enough frames to wrap frame_id
        for (int i = 0; i < 1800; i++) begin
            cyc(0, ($urandom % 4) != 0, rnd_word(), ($urandom % 8) != 0);
        end

        // Random run with heavier backpressure and occasional resets
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom % 100) == 0, ($urandom % 3) != 0, rnd_word(), ($urandom % 2) == 0);
        end
        repeat (2) cyc(0, 0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
